// File: rtl/pencere_besleyici.sv
// 3x3 window former feeding a 10-slot streaming median unit; result strobes 12..21 cycles after the completing pixel.
// Input stalls (ready low) while a completed window waits for the next serializing period.
module pencere_besleyici #(
    parameter int GENISLIK  = 320,
    parameter int PIXEL_BIT = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PIXEL_BIT-1:0] piksel_i,
    input  logic                 piksel_gecerli_i,
    input  logic                 cerceve_basi_i,
    output logic                 piksel_hazir_o,
    output logic [PIXEL_BIT-1:0] sayi_o,
    input  logic [PIXEL_BIT-1:0] medyan_i,
    input  logic                 medyan_hazir_i,
    output logic [PIXEL_BIT-1:0] cikis_o,
    output logic                 cikis_gecerli_o,
    output logic                 hata_o
);

    localparam int              SW        = (GENISLIK > 1) ? $clog2(GENISLIK) : 1;
    localparam logic [SW-1:0]   SON_SUTUN = SW'(GENISLIK - 1);
    localparam logic [15:0]     SATIR_MAX = '1;

    typedef logic [PIXEL_BIT-1:0] piksel_t;

    logic [SW-1:0] sutun, c_etkin;
    logic [15:0]   satir, r_etkin;
    piksel_t       lb0 [GENISLIK];
    piksel_t       lb1 [GENISLIK];
    piksel_t       pencere      [9];
    piksel_t       pencere_yeni [9];
    piksel_t       snapshot     [9];
    piksel_t       seri         [9];
    logic          bekleyen, etiket;
    logic [3:0]    sayac;
    logic          aktar, tamam, yukle, son_slot;

    always_comb begin
        aktar    = piksel_gecerli_i & ~bekleyen & ~rst_i;
        // A start-of-frame pixel is placed at (0,0) regardless of the counters.
        c_etkin  = cerceve_basi_i ? '0 : sutun;
        r_etkin  = cerceve_basi_i ? '0 : satir;
        tamam    = (r_etkin >= 16'd2) && (c_etkin >= SW'(2));
        son_slot = (sayac == 4'd9);
        yukle    = son_slot & bekleyen;
        for (int i = 0; i < 3; i++) begin
            pencere_yeni[3*i]   = pencere[3*i+1];
            pencere_yeni[3*i+1] = pencere[3*i+2];
        end
        pencere_yeni[2] = lb0[c_etkin];
        pencere_yeni[5] = lb1[c_etkin];
        pencere_yeni[8] = piksel_i;
    end

    assign piksel_hazir_o = ~bekleyen;
    assign sayi_o         = (etiket && !son_slot) ? seri[sayac] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sutun <= '0;
            satir <= '0;
        end else if (aktar) begin
            if (c_etkin == SON_SUTUN) begin
                sutun <= '0;
                satir <= (r_etkin == SATIR_MAX) ? r_etkin : r_etkin + 16'd1;
            end else begin
                sutun <= c_etkin + SW'(1);
                satir <= r_etkin;
            end
        end
    end

    // Line buffers and window storage carry no reset; rows 0-1 refill them before use.
    always_ff @(posedge clk_i) begin
        if (aktar) begin
            lb0[c_etkin] <= lb1[c_etkin];
            lb1[c_etkin] <= piksel_i;
            pencere      <= pencere_yeni;
            if (tamam) begin
                snapshot <= pencere_yeni;
            end
        end
        if (yukle) begin
            seri <= snapshot;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sayac           <= 4'd0;
            bekleyen        <= 1'b0;
            etiket          <= 1'b0;
            cikis_o         <= '0;
            cikis_gecerli_o <= 1'b0;
            hata_o          <= 1'b0;
        end else begin
            sayac <= son_slot ? 4'd0 : sayac + 4'd1;
            if (yukle) begin
                bekleyen <= 1'b0;
            end else if (aktar && tamam) begin
                bekleyen <= 1'b1;
            end
            if (son_slot) begin
                etiket <= bekleyen;
            end
            if (medyan_hazir_i && etiket) begin
                cikis_o         <= medyan_i;
                cikis_gecerli_o <= 1'b1;
            end else begin
                cikis_gecerli_o <= 1'b0;
            end
            if (medyan_hazir_i != son_slot) begin
                hata_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pencere_besleyici.sv
// Directed bench: two instances (width 4 and 3) each driven by a behavioural 10-slot median unit.
module tb_pencere_besleyici;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, gecerli, basi, zorla, sel;
    logic [7:0] piksel;
    logic       rdy4, rdy3, mh4, mh3, vld4, vld3, hata4, hata3;
    logic [7:0] sayi4, sayi3, medyan4, medyan3, cikis4, cikis3;

    pencere_besleyici #(.GENISLIK(4), .PIXEL_BIT(8)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .piksel_i(piksel), .piksel_gecerli_i(gecerli),
        .cerceve_basi_i(basi), .piksel_hazir_o(rdy4), .sayi_o(sayi4),
        .medyan_i(medyan4), .medyan_hazir_i(mh4), .cikis_o(cikis4),
        .cikis_gecerli_o(vld4), .hata_o(hata4));

    pencere_besleyici #(.GENISLIK(3), .PIXEL_BIT(8)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .piksel_i(piksel), .piksel_gecerli_i(gecerli),
        .cerceve_basi_i(basi), .piksel_hazir_o(rdy3), .sayi_o(sayi3),
        .medyan_i(medyan3), .medyan_hazir_i(mh3), .cikis_o(cikis3),
        .cikis_gecerli_o(vld3), .hata_o(hata3));

    // Behavioural median unit: collects sayi in slots 0..8, presents the median in slot 9.
    logic [3:0]      mcnt4, mcnt3;
    logic [8:0][7:0] mbuf4, mbuf3;

    function automatic logic [7:0] median9(input logic [8:0][7:0] a);
        logic [7:0] s [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) s[i] = a[i];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s[4];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mcnt4 <= 4'd0;
            mcnt3 <= 4'd0;
        end else begin
            if (mcnt4 < 4'd9) mbuf4[mcnt4] <= sayi4;
            if (mcnt3 < 4'd9) mbuf3[mcnt3] <= sayi3;
            mcnt4 <= (mcnt4 == 4'd9) ? 4'd0 : mcnt4 + 4'd1;
            mcnt3 <= (mcnt3 == 4'd9) ? 4'd0 : mcnt3 + 4'd1;
        end
    end

    assign mh4     = (mcnt4 == 4'd9) | zorla;
    assign mh3     = (mcnt3 == 4'd9) | zorla;
    assign medyan4 = median9(mbuf4);
    assign medyan3 = median9(mbuf3);

    logic       rdy_s, vld_s, hata_s;
    logic [7:0] sayi_s, cikis_s;
    assign rdy_s   = sel ? rdy3   : rdy4;
    assign vld_s   = sel ? vld3   : vld4;
    assign hata_s  = sel ? hata3  : hata4;
    assign sayi_s  = sel ? sayi3  : sayi4;
    assign cikis_s = sel ? cikis3 : cikis4;

    int         checks = 0;
    int         errors = 0;
    int         stalls;
    logic [7:0] q [$];

    always @(negedge clk) begin
        if (!rst && vld_s) q.push_back(cikis_s);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; gecerli = 1'b0; basi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] p, input logic sop);
        int t;
        t = 0;
        piksel = p; gecerli = 1'b1; basi = sop;
        while (!rdy_s && t < 40) begin
            stalls++;
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("send_ready", int'(rdy_s), 1);
        @(negedge clk);
        basi = 1'b0;
    endtask

    task automatic idle(input int n);
        gecerli = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_slot0();
        int t;
        t = 0;
        while (sayi_s == 8'd0 && t < 40) begin
            @(negedge clk);
            t++;
        end
    endtask

    int         v0, v1, v2, v3;
    logic [7:0] taze [9];

    initial begin
        rst = 1'b1; piksel = 8'd0; gecerli = 1'b0; basi = 1'b0; zorla = 1'b0; sel = 1'b0; stalls = 0;
        taze = '{8'd20, 8'd50, 8'd10, 8'd90, 8'd30, 8'd70, 8'd40, 8'd80, 8'd60};

        // Reset values and idle behaviour
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", int'(rdy4), 1);
        chk("rst_sayi", int'(sayi4), 0);
        chk("rst_cikis", int'(cikis4), 0);
        chk("rst_vld", int'(vld4), 0);
        chk("rst_hata", int'(hata4), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_sayi", int'(sayi_s), 0);
            chk("idle_vld", int'(vld_s), 0);
            chk("idle_hata", int'(hata_s), 0);
        end

        // Constant image, width 4, 3 rows
        sel = 1'b0; do_reset(); q.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                send(8'd7, (r == 0 && c == 0));
        idle(50);
        v0 = (q.size() > 0) ? int'(q[0]) : -1;
        v1 = (q.size() > 1) ? int'(q[1]) : -1;
        chk("const_count", q.size(), 2);
        chk("const_0", v0, 7);
        chk("const_1", v1, 7);
        chk("const_hata", int'(hata_s), 0);

        // Ramp window, width 3: slot-by-slot sayi and strobe timing
        sel = 1'b1; do_reset(); q.delete();
        for (int i = 0; i < 9; i++) send(8'(i + 1), (i == 0));
        gecerli = 1'b0;
        wait_slot0();
        for (int k = 0; k < 10; k++) begin
            chk("ramp_sayi", int'(sayi_s), (k < 9) ? k + 1 : 0);
            @(negedge clk);
        end
        chk("ramp_vld", int'(vld_s), 1);
        chk("ramp_cikis", int'(cikis_s), 5);
        idle(20);
        chk("ramp_count", q.size(), 1);

        // Backpressure, width 4, 4 rows, pixel = 10*row+col
        sel = 1'b0; do_reset(); q.delete(); stalls = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                send(8'(10 * r + c), (r == 0 && c == 0));
        idle(60);
        v0 = (q.size() > 0) ? int'(q[0]) : -1;
        v1 = (q.size() > 1) ? int'(q[1]) : -1;
        v2 = (q.size() > 2) ? int'(q[2]) : -1;
        v3 = (q.size() > 3) ? int'(q[3]) : -1;
        chk("bp_stalled", int'(stalls > 0), 1);
        chk("bp_count", q.size(), 4);
        chk("bp_0", v0, 11);
        chk("bp_1", v1, 12);
        chk("bp_2", v2, 21);
        chk("bp_3", v3, 22);

        // Reset in slot 4 aborts the window; a fresh frame is filtered correctly
        sel = 1'b1; do_reset(); q.delete();
        for (int i = 0; i < 9; i++) send(8'(i + 1), (i == 0));
        gecerli = 1'b0;
        wait_slot0();
        repeat (4) @(negedge clk);
        chk("mid_slot4", int'(sayi_s), 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(30);
        chk("mid_aborted", q.size(), 0);
        for (int i = 0; i < 9; i++) send(taze[i], (i == 0));
        idle(50);
        v0 = (q.size() > 0) ? int'(q[0]) : -1;
        chk("mid_count", q.size(), 1);
        chk("mid_value", v0, 50);

        // Cadence misalignment sets a sticky flag
        sel = 1'b0; do_reset();
        v0 = 0;
        while (mcnt4 != 4'd3 && v0 < 20) begin
            @(negedge clk);
            v0++;
        end
        chk("cad_before", int'(hata_s), 0);
        zorla = 1'b1;
        @(negedge clk);
        zorla = 1'b0;
        chk("cad_set", int'(hata_s), 1);
        idle(15);
        chk("cad_sticky", int'(hata_s), 1);
        do_reset();
        chk("cad_cleared", int'(hata_s), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
